sparce_skip_engine: RTL and testbench

SPARCE_SKIP_ENGINE -- requirements
Module: sparce_skip_engine

---
 rtl/sparce_skip_engine.sv | 178 +++++++++++++++++
 tb/tb_sparce_skip_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sparce_skip_engine.sv
`default_nettype none
// ============================================================================
// Module   : sparce_skip_engine
// Purpose  : Sparsity-aware fetch redirect. Tracks which architectural
//            registers currently hold zero. Also holds a small table of
//            trigger PCs, one per entry. When a fetched PC matches a valid
//            entry and that entry's sparsity condition holds, the engine
//            requests a redirect past skip_len instructions one cycle later.
// Ports    : CLK, RST            - clock, synchronous active-high reset
//            pc, fetch_valid     - fetch-stage PC and its qualifier
//            flush               - pipeline squash (suppresses redirect)
//            wb_en/reg/data      - register writeback snoop
//            sasa_wen/addr/data  - skip-table configuration stores
//            skipping            - one-cycle redirect pulse
//            sparce_target       - redirect PC (held between pulses)
//            skip_count          - saturating count of issued skips
// Revision : 1.0 - initial release
// ============================================================================
module sparce_skip_engine #(
  parameter int          SASA_ENTRIES = 8,
  parameter logic [31:0] SASA_BASE    = 32'h0000_2000,
  parameter int          NUM_REGS     = 32,
  localparam int         RW           = $clog2(NUM_REGS),
  localparam int         IW           = $clog2(SASA_ENTRIES)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   pc,
  input  logic          fetch_valid,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_reg,
  input  logic [31:0]   wb_data,
  input  logic          sasa_wen,
  input  logic [31:0]   sasa_addr,
  input  logic [31:0]   sasa_data,
  output logic          skipping,
  output logic [31:0]   sparce_target,
  output logic [31:0]   skip_count
);

  // Skip-table storage
  logic [31:0]             trig_pc_q [SASA_ENTRIES];
  logic [RW-1:0]           rs1_q     [SASA_ENTRIES];
  logic [RW-1:0]           rs2_q     [SASA_ENTRIES];
  logic [15:0]             len_q     [SASA_ENTRIES];
  logic [SASA_ENTRIES-1:0] valid_q;
  logic [SASA_ENTRIES-1:0] mode_q;
  // Set when an entry fires; cleared once a fetch shows a different PC
  logic [SASA_ENTRIES-1:0] supp_q;

  // Sparsity vector: bit i set means register i is known to hold zero
  logic [NUM_REGS-1:0]     sv_q;

  logic                    skipping_q;
  logic [31:0]             target_q;
  logic [31:0]             count_q;

  // --------------------------------------------------------------------------
  // Configuration window decode
  // --------------------------------------------------------------------------
  logic [31:0]   w_cfg_off;
  logic          w_cfg_hit;
  logic [IW-1:0] w_cfg_idx;
  logic          w_cfg_word;

  assign w_cfg_off  = sasa_addr - SASA_BASE;
  assign w_cfg_hit  = sasa_wen
                    && (sasa_addr >= SASA_BASE)
                    && (w_cfg_off < 32'(8 * SASA_ENTRIES))
                    && (sasa_addr[1:0] == 2'b00);
  assign w_cfg_idx  = w_cfg_off[IW+2:3];
  assign w_cfg_word = sasa_addr[2];

  // --------------------------------------------------------------------------
  // Per-entry match, evaluated against registered table and sparsity state
  // so same-cycle writebacks and config stores are not visible.
  // --------------------------------------------------------------------------
  logic [SASA_ENTRIES-1:0] w_hit;

  for (genvar g = 0; g < SASA_ENTRIES; g++) begin : g_entry
    logic w_cond;
    assign w_cond   = mode_q[g] ? (sv_q[rs1_q[g]] | sv_q[rs2_q[g]])
                                :  sv_q[rs1_q[g]];
    assign w_hit[g] = fetch_valid && !flush && valid_q[g]
                    && (trig_pc_q[g] == pc) && (len_q[g] != 16'd0)
                    && w_cond && !supp_q[g];
  end

  // Lowest-index hit wins: scan high to low so the last assignment sticks.
  logic          w_any;
  logic [IW-1:0] w_win_idx;
  logic [15:0]   w_win_len;

  always_comb begin
    w_any     = |w_hit;
    w_win_idx = '0;
    w_win_len = '0;
    for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win_idx = IW'(i);
        w_win_len = len_q[i];
      end
    end
  end

  logic [31:0] target_d;
  assign target_d = pc + {14'd0, w_win_len, 2'b00};

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      skipping_q <= 1'b0;
      target_q   <= '0;
      count_q    <= '0;
      sv_q       <= '1;
      valid_q    <= '0;
      mode_q     <= '0;
      supp_q     <= '0;
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        trig_pc_q[i] <= '0;
        rs1_q[i]     <= '0;
        rs2_q[i]     <= '0;
        len_q[i]     <= '0;
      end
    end else begin
      skipping_q <= w_any;
      if (w_any) begin
        target_q <= target_d;
        if (count_q != 32'hFFFF_FFFF) begin
          count_q <= count_q + 32'd1;
        end
      end

      // Register 0 is hardwired zero, so its bit is never rewritten.
      if (wb_en && (wb_reg != '0)) begin
        sv_q[wb_reg] <= (wb_data == 32'd0);
      end

      // A fire can only occur when pc equals trig_pc, so the set below
      // never collides with the clear for the same entry.
      for (int i = 0; i < SASA_ENTRIES; i++) begin
        if (fetch_valid && (pc != trig_pc_q[i])) begin
          supp_q[i] <= 1'b0;
        end
      end
      if (w_any) begin
        supp_q[w_win_idx] <= 1'b1;
      end

      if (w_cfg_hit) begin
        if (!w_cfg_word) begin
          // Rewriting the trigger PC disarms the entry until word 1 is set.
          trig_pc_q[w_cfg_idx] <= sasa_data;
          valid_q[w_cfg_idx]   <= 1'b0;
        end else begin
          valid_q[w_cfg_idx] <= sasa_data[31];
          rs1_q[w_cfg_idx]   <= sasa_data[26 +: RW];
          rs2_q[w_cfg_idx]   <= sasa_data[21 +: RW];
          mode_q[w_cfg_idx]  <= sasa_data[20];
          len_q[w_cfg_idx]   <= sasa_data[15:0];
        end
      end
    end
  end

  assign skipping      = skipping_q;
  assign sparce_target = target_q;
  assign skip_count    = count_q;

  // Offset high bits and unmapped data bits carry no meaning here.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_cfg_off, sasa_data};

endmodule
`default_nettype wire

// File: tb/tb_sparce_skip_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparce_skip_engine
// Purpose  : Directed self-checking bench for sparce_skip_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparce_skip_engine;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        sasa_wen;
  logic [31:0] sasa_addr;
  logic [31:0] sasa_data;
  logic        skipping;
  logic [31:0] sparce_target;
  logic [31:0] skip_count;

  int n_checks = 0;
  int n_fail   = 0;

  sparce_skip_engine dut (
    .CLK           (CLK),
    .RST           (RST),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .sasa_wen      (sasa_wen),
    .sasa_addr     (sasa_addr),
    .sasa_data     (sasa_data),
    .skipping      (skipping),
    .sparce_target (sparce_target),
    .skip_count    (skip_count)
  );

  always #5 CLK = ~CLK;

  // Advance one cycle; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [31:0] a, input logic [31:0] d);
    sasa_wen = 1'b1; sasa_addr = a; sasa_data = d;
    tick();
    sasa_wen = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] p);
    fetch_valid = 1'b1; pc = p;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL reset_skipping got=%0b exp=0", skipping); end
    n_checks++;
    if (sparce_target !== 32'h0) begin n_fail++; $display("FAIL reset_target got=%h exp=0", sparce_target); end
    n_checks++;
    if (skip_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", skip_count); end
  endtask

  task automatic test_basic();
    cfg(32'h2000, 32'h0000_0100);
    cfg(32'h2004, 32'h9400_0004);   // valid, rs1=5, mode0, len 4
    fetch(32'h100);
    n_checks++;
    if (skipping !== 1'b1) begin n_fail++; $display("FAIL basic_skip got=%0b exp=1", skipping); end
    n_checks++;
    if (sparce_target !== 32'h110) begin n_fail++; $display("FAIL basic_target got=%h exp=110", sparce_target); end
    n_checks++;
    if (skip_count !== 32'd1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", skip_count); end
    tick();
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got=%0b exp=0", skipping); end
    fetch(32'h104);
  endtask

  task automatic test_sparsity();
    wb(5'd5, 32'd7);
    fetch(32'h100);
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL sv_nonzero got=%0b exp=0", skipping); end
    n_checks++;
    if (sparce_target !== 32'h110) begin n_fail++; $display("FAIL sv_target_hold got=%h exp=110", sparce_target); end
    // Writeback of zero in the same cycle as the fetch is not yet visible
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'd0;
    fetch(32'h100);
    wb_en = 1'b0;
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL sv_same_cycle got=%0b exp=0", skipping); end
    fetch(32'h100);
    n_checks++;
    if (skipping !== 1'b1) begin n_fail++; $display("FAIL sv_next_fetch got=%0b exp=1", skipping); end
    n_checks++;
    if (skip_count !== 32'd2) begin n_fail++; $display("FAIL sv_count got=%0d exp=2", skip_count); end
    fetch(32'h104);
  endtask

  task automatic test_priority();
    wb(5'd0, 32'd5);                // ignored: x0 stays zero
    wb(5'd6, 32'd1);                // x6 nonzero
    cfg(32'h2010, 32'h0000_0200);
    cfg(32'h2014, 32'h8000_0001);   // entry2: rs1=0, len 1
    cfg(32'h2028, 32'h0000_0200);
    cfg(32'h202C, 32'h9400_0003);   // entry5: rs1=5, len 3
    fetch(32'h200);
    n_checks++;
    if (sparce_target !== 32'h204 || skipping !== 1'b1) begin
      n_fail++; $display("FAIL prio_target got=%h skip=%0b exp=204 skip=1", sparce_target, skipping);
    end
    n_checks++;
    if (skip_count !== 32'd3) begin n_fail++; $display("FAIL prio_count got=%0d exp=3", skip_count); end
    cfg(32'h2008, 32'h0000_0300);
    cfg(32'h200C, 32'h9800_0007);   // entry1: mode0 rs1=6 (nonzero) -> no match
    cfg(32'h2018, 32'h0000_0300);
    cfg(32'h201C, 32'h98B0_0002);   // entry3: mode1 rs1=6 rs2=5 -> match
    fetch(32'h300);
    n_checks++;
    if (sparce_target !== 32'h308 || skipping !== 1'b1) begin
      n_fail++; $display("FAIL mode1_target got=%h skip=%0b exp=308 skip=1", sparce_target, skipping);
    end
    n_checks++;
    if (skip_count !== 32'd4) begin n_fail++; $display("FAIL mode1_count got=%0d exp=4", skip_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    fetch_valid = 1'b1; pc = 32'h100;
    tick(); obs[0] = skipping;
    tick(); obs[1] = skipping;
    tick(); obs[2] = skipping;
    pc = 32'h104;
    tick(); obs[3] = skipping;
    n_checks++;
    if (obs !== 4'b0001) begin n_fail++; $display("FAIL retrig_hold got=%b exp=0001", obs); end
    pc = 32'h100;
    tick();
    fetch_valid = 1'b0;
    n_checks++;
    if (skipping !== 1'b1) begin n_fail++; $display("FAIL retrig_second got=%0b exp=1", skipping); end
    n_checks++;
    if (skip_count !== 32'd6) begin n_fail++; $display("FAIL retrig_count got=%0d exp=6", skip_count); end
  endtask

  task automatic test_bad_writes();
    cfg(32'h2040, 32'h0000_0500);   // one past the window
    cfg(32'h2044, 32'h8000_0001);
    cfg(32'h2002, 32'h0000_0600);   // misaligned
    cfg(32'h1FF8, 32'h0000_0700);   // below the window
    fetch(32'h104);
    fetch(32'h100);
    n_checks++;
    if (skipping !== 1'b1 || sparce_target !== 32'h110) begin
      n_fail++; $display("FAIL bad_write got skip=%0b tgt=%h exp skip=1 tgt=110", skipping, sparce_target);
    end
    cfg(32'h2030, 32'hFFFF_FFFC);
    cfg(32'h2034, 32'h8000_0002);   // entry6: rs1=0, len 2
    fetch(32'hFFFF_FFFC);
    n_checks++;
    if (skipping !== 1'b1 || sparce_target !== 32'h4) begin
      n_fail++; $display("FAIL wrap got skip=%0b tgt=%h exp skip=1 tgt=4", skipping, sparce_target);
    end
    n_checks++;
    if (skip_count !== 32'd8) begin n_fail++; $display("FAIL wrap_count got=%0d exp=8", skip_count); end
  endtask

  task automatic test_flush_reset();
    wb(5'd7, 32'd3);                // x7 nonzero before reset
    flush = 1'b1;
    fetch(32'h100);
    flush = 1'b0;
    n_checks++;
    if (skipping !== 1'b0 || skip_count !== 32'd8 || sparce_target !== 32'h4) begin
      n_fail++; $display("FAIL flush got skip=%0b cnt=%0d tgt=%h exp 0 8 4", skipping, skip_count, sparce_target);
    end
    // Reset coincides with a matching fetch: the pending skip is dropped
    RST = 1'b1;
    fetch(32'h100);
    RST = 1'b0;
    n_checks++;
    if (skipping !== 1'b0 || skip_count !== 32'd0 || sparce_target !== 32'h0) begin
      n_fail++; $display("FAIL rst_pending got skip=%0b cnt=%0d tgt=%h exp 0 0 0", skipping, skip_count, sparce_target);
    end
    fetch(32'h100);
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL rst_invalid0 got=%0b exp=0", skipping); end
    fetch(32'h200);
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL rst_invalid2 got=%0b exp=0", skipping); end
    // SV[7] is set again by reset; config store in fetch cycle is not yet seen
    cfg(32'h2008, 32'h0000_0700);
    sasa_wen = 1'b1; sasa_addr = 32'h200C; sasa_data = 32'h9C00_0001;
    fetch(32'h700);
    sasa_wen = 1'b0;
    n_checks++;
    if (skipping !== 1'b0) begin n_fail++; $display("FAIL cfg_same_cycle got=%0b exp=0", skipping); end
    fetch(32'h700);
    n_checks++;
    if (skipping !== 1'b1 || sparce_target !== 32'h704 || skip_count !== 32'd1) begin
      n_fail++; $display("FAIL rst_sv got skip=%0b tgt=%h cnt=%0d exp 1 704 1", skipping, sparce_target, skip_count);
    end
  endtask

  initial begin
    RST = 1'b1; pc = '0; fetch_valid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    sasa_wen = 1'b0; sasa_addr = '0; sasa_data = '0;
    test_reset();
    test_basic();
    test_sparsity();
    test_priority();
    test_back_to_back();
    test_bad_writes();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
